// File: rtl/disp_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg -- shared types and constants for the display scheduler.
//   state_t   : scheduler FSM states
//   digit_t   : one display-driver digit field {enable, value[3:0], dp}
//   BLANK     : digit field with the enable cleared
//   DWELL_DEF : default number of tick pulses a sample stays on the display
//   NUM_REQ   : number of requesters sharing the display
//   mk_digit  : builds an enabled digit field without decimal point
// ----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_CONV  = 2'd2,
        S_SHOW  = 2'd3
    } state_t;

    typedef logic [5:0] digit_t;

    localparam digit_t      BLANK     = 6'd0;
    localparam int unsigned DWELL_DEF = 1000;
    localparam int          NUM_REQ   = 4;

    function automatic digit_t mk_digit(input logic [3:0] v);
        return {1'b1, v, 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq -- sequential 16-bit binary to 5-digit BCD converter using the
// shift-add-3 method, one bit per clock.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset (control state only)
//   i_start : one-cycle pulse, loads i_bin and begins a conversion
//   i_bin   : unsigned value to convert
//   o_done  : high from the end of the 16th iteration until the next start
//   o_bcd   : five packed BCD digits, units in [3:0]; valid while o_done
// ----------------------------------------------------------------------------
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_bin,
    output logic        o_done,
    output logic [19:0] o_bcd
);

    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_act;
    logic [19:0] w_adj;

    // Any BCD digit of 5 or more would overflow past 9 when doubled,
    // so it is pre-corrected by 3 before the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act <= 1'b0;
            r_cnt <= 5'd0;
        end else if (i_start) begin
            r_act <= 1'b1;
            r_cnt <= 5'd16;
        end else if (r_act && (r_cnt != 5'd0)) begin
            r_cnt <= r_cnt - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_bin <= i_bin;
            r_bcd <= '0;
        end else if (r_act && (r_cnt != 5'd0)) begin
            {r_bcd, r_bin} <= {w_adj[18:0], r_bin, 1'b0};
        end
    end

    assign o_done = r_act && (r_cnt == 5'd0);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/disp_sched.sv
// ----------------------------------------------------------------------------
// disp_sched -- round-robin scheduler that shares one 8-digit display among
// four requesters. A granted requester's 16-bit value is converted to BCD and
// shown on d1..d4 together with its mode (d6) and index (d8) for DWELL ticks.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   tick    : one-cycle dwell-time enable, counted only while showing
//   req     : per-requester level-sensitive request
//   data_in : requester k value in [16k+15:16k]
//   mod_in  : requester k mode in [2k+1:2k]
//   ack     : one-hot one-cycle pulse when requester k is sampled
//   sel     : index of the requester currently granted/shown
//   busy    : high whenever the FSM is not idle
//   d1..d8  : digit fields {enable, value[3:0], dp} for the display driver
// ----------------------------------------------------------------------------
module disp_sched
    import disp_pkg::*;
#(
    parameter int unsigned DWELL = DWELL_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [3:0]  req,
    input  logic [63:0] data_in,
    input  logic [7:0]  mod_in,
    output logic [3:0]  ack,
    output logic [1:0]  sel,
    output logic        busy,
    output digit_t      d1,
    output digit_t      d2,
    output digit_t      d3,
    output digit_t      d4,
    output digit_t      d5,
    output digit_t      d6,
    output digit_t      d7,
    output digit_t      d8
);

    localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);

    state_t      r_state, w_next;
    logic [1:0]  r_last, r_sel, r_mode;
    logic [3:0]  r_ack;
    logic [15:0] r_dwell;
    digit_t      r_d1, r_d2, r_d3, r_d4, r_d5, r_d6, r_d7, r_d8;

    logic        w_found;
    logic [1:0]  w_win, w_try;
    logic        w_grant, w_load, w_dinc;
    logic        w_done;
    logic [19:0] w_bcd;
    logic        w_unused;

    // Round-robin search starting just after the last granted index; the
    // 2-bit add wraps naturally so index 3 is followed by index 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_try   = 2'd0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_try = r_last + 2'(i);
            if (!w_found && req[w_try]) begin
                w_found = 1'b1;
                w_win   = w_try;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_load  = 1'b0;
        w_dinc  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|req) w_next = S_GRANT;
            end
            S_GRANT: begin
                // Requester may have withdrawn since IDLE saw it.
                if (w_found) begin
                    w_grant = 1'b1;
                    w_next  = S_CONV;
                end else begin
                    w_next  = S_IDLE;
                end
            end
            S_CONV: begin
                if (w_done) begin
                    w_load = 1'b1;
                    w_next = S_SHOW;
                end
            end
            S_SHOW: begin
                if (tick) begin
                    if (r_dwell == DWELL_M1) begin
                        w_next = (|req) ? S_GRANT : S_IDLE;
                    end else begin
                        w_dinc = 1'b1;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_grant),
        .i_bin   (data_in[16*w_win +: 16]),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    // Ten-thousands digit is not displayed.
    assign w_unused = ^w_bcd[19:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 4'd0;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
            r_mode  <= 2'd0;
            r_dwell <= 16'd0;
            r_d1    <= BLANK;
            r_d2    <= BLANK;
            r_d3    <= BLANK;
            r_d4    <= BLANK;
            r_d5    <= BLANK;
            r_d6    <= BLANK;
            r_d7    <= BLANK;
            r_d8    <= BLANK;
        end else begin
            r_ack <= 4'd0;
            if (w_grant) begin
                r_ack  <= 4'b0001 << w_win;
                r_sel  <= w_win;
                r_last <= w_win;
                r_mode <= mod_in[2*w_win +: 2];
            end
            // All digit fields load together so no partial result is seen.
            if (w_load) begin
                r_dwell <= 16'd0;
                r_d1    <= mk_digit(w_bcd[3:0]);
                r_d2    <= mk_digit(w_bcd[7:4]);
                r_d3    <= mk_digit(w_bcd[11:8]);
                r_d4    <= mk_digit(w_bcd[15:12]);
                r_d5    <= BLANK;
                r_d6    <= mk_digit({2'b00, r_mode});
                r_d7    <= BLANK;
                r_d8    <= mk_digit({2'b00, r_sel});
            end else if (w_dinc) begin
                r_dwell <= r_dwell + 16'd1;
            end
        end
    end

    assign ack  = r_ack;
    assign sel  = r_sel;
    assign busy = (r_state != S_IDLE);
    assign d1   = r_d1;
    assign d2   = r_d2;
    assign d3   = r_d3;
    assign d4   = r_d4;
    assign d5   = r_d5;
    assign d6   = r_d6;
    assign d7   = r_d7;
    assign d8   = r_d8;

endmodule

// File: tb/tb_disp_sched.sv
// ----------------------------------------------------------------------------
// tb_disp_sched -- directed self-checking bench for disp_sched. Two instances
// share the stimulus: one with DWELL=2, one with DWELL=3.
// ----------------------------------------------------------------------------
module tb_disp_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [63:0] data_in = 64'd0;
    logic [7:0]  mod_in = 8'd0;

    logic [3:0]  a2, a3;
    logic [1:0]  s2, s3;
    logic        b2, b3;
    logic [5:0]  q2 [1:8];
    logic [5:0]  q3 [1:8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    disp_sched #(.DWELL(2)) u_dut2 (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .data_in(data_in), .mod_in(mod_in),
        .ack(a2), .sel(s2), .busy(b2),
        .d1(q2[1]), .d2(q2[2]), .d3(q2[3]), .d4(q2[4]),
        .d5(q2[5]), .d6(q2[6]), .d7(q2[7]), .d8(q2[8])
    );

    disp_sched #(.DWELL(3)) u_dut3 (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .data_in(data_in), .mod_in(mod_in),
        .ack(a3), .sel(s3), .busy(b3),
        .d1(q3[1]), .d2(q3[2]), .d3(q3[3]), .d4(q3[4]),
        .d5(q3[5]), .d6(q3[6]), .d7(q3[7]), .d8(q3[8])
    );

    function automatic logic [5:0] dig(input logic [3:0] v);
        return {1'b1, v, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'd0;
        tick = 1'b0;
        steps(2);
        rst  = 1'b0;
    endtask

    task automatic wait_ack(input bit use3, output logic [3:0] got);
        got = 4'd0;
        for (int n = 0; n < 100; n++) begin
            step();
            got = use3 ? a3 : a2;
            if (got != 4'd0) return;
        end
        total++;
        bad++;
        $display("FAIL wait_ack: no ack within 100 cycles, got=%b required=nonzero", got);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; tick = 1'b1;
        step();
        total++; if (a2 !== 4'd0) begin bad++; $display("FAIL reset_ack: got=%b required=0000", a2); end
        total++; if (s2 !== 2'd0) begin bad++; $display("FAIL reset_sel: got=%0d required=0", s2); end
        total++; if (b2 !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b required=0", b2); end
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (q2[k] !== 6'd0) begin bad++; $display("FAIL reset_d%0d: got=%h required=00", k, q2[k]); end
        end
        rst = 1'b0; req = 4'd0; tick = 1'b0;
        step();
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0001;
        step();
        total++; if (b2 !== 1'b1) begin bad++; $display("FAIL withdraw_busy_grant: got=%b required=1", b2); end
        req = 4'b0000;
        step();
        total++; if (a2 !== 4'd0) begin bad++; $display("FAIL withdraw_ack: got=%b required=0000", a2); end
        total++; if (b2 !== 1'b0) begin bad++; $display("FAIL withdraw_idle: got=%b required=0", b2); end
    endtask

    task automatic test_basic();
        logic [3:0] got;
        do_reset();
        data_in = 64'd0; data_in[15:0] = 16'd1234;
        mod_in  = 8'b0000_0010;
        req     = 4'b0001;
        wait_ack(1'b0, got);
        total++; if (got !== 4'b0001) begin bad++; $display("FAIL basic_ack: got=%b required=0001", got); end
        total++; if (s2 !== 2'd0) begin bad++; $display("FAIL basic_sel: got=%0d required=0", s2); end
        req = 4'b0000;
        step();
        total++; if (a2 !== 4'd0) begin bad++; $display("FAIL basic_ack_width: got=%b required=0000", a2); end
        steps(15);
        total++; if (q2[1] !== 6'd0) begin bad++; $display("FAIL basic_early: d1 got=%h required=00", q2[1]); end
        step();
        total++; if (q2[1] !== dig(4)) begin bad++; $display("FAIL basic_d1: got=%h required=%h", q2[1], dig(4)); end
        total++; if (q2[2] !== dig(3)) begin bad++; $display("FAIL basic_d2: got=%h required=%h", q2[2], dig(3)); end
        total++; if (q2[3] !== dig(2)) begin bad++; $display("FAIL basic_d3: got=%h required=%h", q2[3], dig(2)); end
        total++; if (q2[4] !== dig(1)) begin bad++; $display("FAIL basic_d4: got=%h required=%h", q2[4], dig(1)); end
        total++; if (q2[6] !== dig(2)) begin bad++; $display("FAIL basic_d6: got=%h required=%h", q2[6], dig(2)); end
        total++; if (q2[8] !== dig(0)) begin bad++; $display("FAIL basic_d8: got=%h required=%h", q2[8], dig(0)); end
        total++; if ((q2[5] !== 6'd0) || (q2[7] !== 6'd0)) begin bad++; $display("FAIL basic_blank: d5=%h d7=%h required=00", q2[5], q2[7]); end
    endtask

    task automatic test_round_robin();
        logic [3:0] got;
        logic [5:0] prev;
        int         exp_order [5] = '{0, 1, 2, 3, 0};
        int         g;
        do_reset();
        data_in = {16'd4444, 16'd3333, 16'd2222, 16'd1111};
        mod_in  = 8'b11_10_01_00;
        req     = 4'b1111;
        tick    = 1'b1;
        prev    = 6'd0;
        for (int n = 0; n < 5; n++) begin
            g = exp_order[n];
            wait_ack(1'b0, got);
            total++; if (got !== (4'b0001 << g)) begin bad++; $display("FAIL rr_ack%0d: got=%b required=%b", n, got, 4'b0001 << g); end
            total++; if (s2 !== 2'(g)) begin bad++; $display("FAIL rr_sel%0d: got=%0d required=%0d", n, s2, g); end
            step();
            total++; if (a2 !== 4'd0) begin bad++; $display("FAIL rr_ack_width%0d: got=%b required=0000", n, a2); end
            steps(15);
            total++; if (q2[1] !== prev) begin bad++; $display("FAIL rr_hold%0d: d1 got=%h required=%h", n, q2[1], prev); end
            step();
            total++; if (q2[1] !== dig(4'(g + 1))) begin bad++; $display("FAIL rr_d1_%0d: got=%h required=%h", n, q2[1], dig(4'(g + 1))); end
            total++; if (q2[6] !== dig(4'(g))) begin bad++; $display("FAIL rr_d6_%0d: got=%h required=%h", n, q2[6], dig(4'(g))); end
            total++; if (q2[8] !== dig(4'(g))) begin bad++; $display("FAIL rr_d8_%0d: got=%h required=%h", n, q2[8], dig(4'(g))); end
            prev = dig(4'(g + 1));
        end
        tick = 1'b0;
        req  = 4'd0;
    endtask

    task automatic test_bounds();
        logic [3:0] got;
        do_reset();
        data_in = 64'd0; data_in[15:0] = 16'd65535;
        mod_in  = 8'b0000_0011;
        req     = 4'b0001;
        wait_ack(1'b0, got);
        total++; if (got !== 4'b0001) begin bad++; $display("FAIL max_ack: got=%b required=0001", got); end
        step();
        data_in[15:0] = 16'd0;
        steps(16);
        total++; if (q2[1] !== dig(5)) begin bad++; $display("FAIL max_d1: got=%h required=%h", q2[1], dig(5)); end
        total++; if (q2[2] !== dig(3)) begin bad++; $display("FAIL max_d2: got=%h required=%h", q2[2], dig(3)); end
        total++; if (q2[3] !== dig(5)) begin bad++; $display("FAIL max_d3: got=%h required=%h", q2[3], dig(5)); end
        total++; if (q2[4] !== dig(5)) begin bad++; $display("FAIL max_d4: got=%h required=%h", q2[4], dig(5)); end
        total++; if (q2[6] !== dig(3)) begin bad++; $display("FAIL max_d6: got=%h required=%h", q2[6], dig(3)); end
        tick = 1'b1;
        wait_ack(1'b0, got);
        total++; if (got !== 4'b0001) begin bad++; $display("FAIL regrant_ack: got=%b required=0001", got); end
        tick = 1'b0;
        steps(17);
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (q2[k] !== dig(0)) begin bad++; $display("FAIL zero_d%0d: got=%h required=%h", k, q2[k], dig(0)); end
        end
        req = 4'd0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        do_reset();
        data_in = {16'd0, 16'd9876, 16'd4321, 16'd0};
        mod_in  = 8'b00_01_10_00;
        req     = 4'b0010;
        wait_ack(1'b0, got);
        req = 4'b0100;
        steps(17);
        total++; if (q2[1] !== dig(1)) begin bad++; $display("FAIL mid_pre_d1: got=%h required=%h", q2[1], dig(1)); end
        total++; if (q2[4] !== dig(4)) begin bad++; $display("FAIL mid_pre_d4: got=%h required=%h", q2[4], dig(4)); end
        tick = 1'b1;
        wait_ack(1'b0, got);
        total++; if (got !== 4'b0100) begin bad++; $display("FAIL mid_ack: got=%b required=0100", got); end
        tick = 1'b0;
        req  = 4'd0;
        steps(8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (s2 !== 2'd0) begin bad++; $display("FAIL mid_sel: got=%0d required=0", s2); end
        total++; if (b2 !== 1'b0) begin bad++; $display("FAIL mid_busy: got=%b required=0", b2); end
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (q2[k] !== 6'd0) begin bad++; $display("FAIL mid_d%0d: got=%h required=00", k, q2[k]); end
        end
        steps(10);
        total++; if ((q2[1] !== 6'd0) || (q2[4] !== 6'd0) || (a2 !== 4'd0)) begin
            bad++; $display("FAIL mid_no_update: d1=%h d4=%h ack=%b required=00 00 0000", q2[1], q2[4], a2);
        end
    endtask

    task automatic test_drop();
        logic [3:0] got;
        do_reset();
        data_in = 64'd0; data_in[47:32] = 16'd7;
        mod_in  = 8'b00_11_00_00;
        req     = 4'b0100;
        wait_ack(1'b1, got);
        total++; if (got !== 4'b0100) begin bad++; $display("FAIL drop_ack: got=%b required=0100", got); end
        steps(17);
        total++; if (q3[1] !== dig(7)) begin bad++; $display("FAIL drop_d1: got=%h required=%h", q3[1], dig(7)); end
        req = 4'd0;
        for (int t = 1; t <= 3; t++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            total++;
            if (b3 !== ((t < 3) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL drop_busy_tick%0d: got=%b required=%b", t, b3, (t < 3) ? 1'b1 : 1'b0);
            end
            step();
        end
        for (int t = 0; t < 4; t++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        total++; if (b3 !== 1'b0) begin bad++; $display("FAIL idle_busy: got=%b required=0", b3); end
        total++; if (a3 !== 4'd0) begin bad++; $display("FAIL idle_ack: got=%b required=0000", a3); end
        total++; if (q3[1] !== dig(7)) begin bad++; $display("FAIL hold_d1: got=%h required=%h", q3[1], dig(7)); end
        total++; if (q3[2] !== dig(0)) begin bad++; $display("FAIL hold_d2: got=%h required=%h", q3[2], dig(0)); end
        total++; if (q3[6] !== dig(3)) begin bad++; $display("FAIL hold_d6: got=%h required=%h", q3[6], dig(3)); end
        total++; if (q3[8] !== dig(2)) begin bad++; $display("FAIL hold_d8: got=%h required=%h", q3[8], dig(2)); end
    endtask

    initial begin
        test_reset();
        test_withdraw();
        test_basic();
        test_round_robin();
        test_bounds();
        test_reset_mid();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
